// File: rtl/player_ship.sv
// player_ship
//   Player cannon for the shooter: frame-strobed movement with a velocity
//   ramp and edge clamping, integer sprite scaling, and a life/hit state
//   machine with explosion and (optional) respawn phases.
//
// Optional feature macro: PLAYER_SHIP_INVULN_EN
//   defined   - after an explosion the ship enters a blinking, invulnerable
//               RESPAWN phase lasting INVULN_FRAMES ticks.
//   undefined - the ship returns to ALIVE straight after the explosion;
//               INVULN_FRAMES and BLINK_BIT have no effect.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   frame_tick            : one-cycle strobe per video frame
//   pix_x, pix_y          : current pixel from the VGA timing generator
//   move_left, move_right : debounced level inputs
//   hit                   : one-cycle collision pulse (honoured in ALIVE only)
//   restart               : one-cycle pulse (honoured in GAME_OVER only)
//   ship_x_pos            : registered left edge of the sprite
//   ship_on               : combinational sprite pixel for the mixer
//   lives_left            : registered remaining lives
//   alive / exploding / game_over : state decodes
module player_ship #(
  parameter int SCALE          = 1,
  parameter int SHIP_Y         = 440,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 627,
  parameter int X_RESET        = 312,
  parameter int MAX_SPEED      = 4,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 32,
  parameter int INVULN_FRAMES  = 64,
  parameter int BLINK_BIT      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       hit,
  input  logic       restart,
  output logic [9:0] ship_x_pos,
  output logic       ship_on,
  output logic [3:0] lives_left,
  output logic       alive,
  output logic       exploding,
  output logic       game_over
);

  localparam int SHIFT  = (SCALE >= 4) ? 2 : ((SCALE == 2) ? 1 : 0);
  localparam int SHIP_W = 13 * SCALE;
  localparam int SHIP_H = 8 * SCALE;

`ifdef PLAYER_SHIP_INVULN_EN
  localparam bit INVULN_EN = 1'b1;
`else
  localparam bit INVULN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_EXPLODE,
    ST_RESPAWN,
    ST_GAME_OVER
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [3:0] lives_q, lives_d;
  logic [3:0] vel_q, vel_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;

  logic        move_req;
  logic        dir_move;
  logic [3:0]  vel_move;
  logic [9:0]  x_move;
  logic [10:0] x_wide;
  logic [10:0] step_wide;

  // Candidate position/velocity if this cycle were a movement tick. The
  // clamp comparisons run at 11 bits so x+vel near the right edge and
  // x-vel near zero cannot wrap; the chosen result always fits 10 bits.
  always_comb begin
    move_req  = move_left ^ move_right;
    dir_move  = move_req ? move_right : dir_q;
    x_wide    = {1'b0, x_q};
    if (!move_req) begin
      vel_move = 4'd0;
    end else if (move_right == dir_q) begin
      vel_move = (vel_q >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : vel_q + 4'd1;
    end else begin
      vel_move = 4'd1;
    end
    step_wide = {7'd0, vel_move};
    x_move    = x_q;
    if (move_req && move_right) begin
      if (x_wide + step_wide > 11'(X_MAX)) x_move = 10'(X_MAX);
      else                                 x_move = x_q + {6'd0, vel_move};
    end else if (move_req) begin
      if (x_wide < 11'(X_MIN) + step_wide) x_move = 10'(X_MIN);
      else                                 x_move = x_q - {6'd0, vel_move};
    end
  end

  // Life/hit state machine. cnt counts the frame ticks still owed to the
  // current phase; the tick that takes it from 1 to 0 ends the phase, so a
  // phase entered with cnt=N lasts exactly N later ticks.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    lives_d = lives_q;
    vel_d   = vel_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ALIVE: begin
        if (hit) begin
          lives_d = lives_q - 4'd1;
          cnt_d   = 8'(EXPLODE_FRAMES);
          vel_d   = 4'd0;
          state_d = ST_EXPLODE;
        end else if (frame_tick) begin
          x_d   = x_move;
          vel_d = vel_move;
          dir_d = dir_move;
        end
      end
      ST_EXPLODE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            if (lives_q == 4'd0) begin
              state_d = ST_GAME_OVER;
            end else begin
              x_d   = 10'(X_RESET);
              vel_d = 4'd0;
              if (INVULN_EN) begin
                state_d = ST_RESPAWN;
                cnt_d   = 8'(INVULN_FRAMES);
              end else begin
                state_d = ST_ALIVE;
              end
            end
          end
        end
      end
      ST_RESPAWN: begin
        if (frame_tick) begin
          x_d   = x_move;
          vel_d = vel_move;
          dir_d = dir_move;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_ALIVE;
        end
      end
      ST_GAME_OVER: begin
        if (restart) begin
          lives_d = 4'(LIVES);
          x_d     = 10'(X_RESET);
          vel_d   = 4'd0;
          state_d = ST_ALIVE;
        end
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ALIVE;
      x_q     <= 10'(X_RESET);
      lives_q <= 4'(LIVES);
      vel_q   <= 4'd0;
      dir_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      lives_q <= lives_d;
      vel_q   <= vel_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [10:0] px_w, py_w, dx, dy, col, row;
  logic        in_box, sprite_bit, visible;

  // Sprite lookup. Offsets into the footprint are divided by SCALE with a
  // shift, giving a 13x8 cell grid; rows 4..7 are solid so they need no
  // column test beyond the bounding box.
  always_comb begin
    px_w   = {1'b0, pix_x};
    py_w   = {1'b0, pix_y};
    dx     = px_w - {1'b0, x_q};
    dy     = py_w - 11'(SHIP_Y);
    in_box = (px_w >= {1'b0, x_q}) && (dx < 11'(SHIP_W)) &&
             (py_w >= 11'(SHIP_Y)) && (dy < 11'(SHIP_H));
    col    = dx >> SHIFT;
    row    = dy >> SHIFT;
    case (row)
      11'd0:        sprite_bit = (col == 11'd6);
      11'd1, 11'd2: sprite_bit = (col >= 11'd5) && (col <= 11'd7);
      11'd3:        sprite_bit = (col >= 11'd1) && (col <= 11'd11);
      default:      sprite_bit = 1'b1;
    endcase
    visible = (state_q == ST_ALIVE) ||
              (INVULN_EN && (state_q == ST_RESPAWN) && !cnt_q[BLINK_BIT]);
    ship_on = in_box && sprite_bit && visible;
  end

  assign ship_x_pos = x_q;
  assign lives_left = lives_q;
  assign alive      = (state_q == ST_ALIVE) || (state_q == ST_RESPAWN);
  assign exploding  = (state_q == ST_EXPLODE);
  assign game_over  = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_player_ship.sv
// Testbench for player_ship: two instances (SCALE=1 and SCALE=2) share all
// inputs; a behavioural model tracks phases as "ticks remaining" and draws
// the sprite from a picture of the ship.
module tb_player_ship;

  localparam int SHIP_Y         = 440;
  localparam int X_MIN          = 0;
  localparam int X_RESET        = 312;
  localparam int MAX_SPEED      = 4;
  localparam int LIVES          = 3;
  localparam int EXPLODE_FRAMES = 32;
  localparam int INVULN_FRAMES  = 64;
  localparam int BLINK_BIT      = 2;

  localparam int PH_ALIVE   = 0;
  localparam int PH_EXPLODE = 1;
  localparam int PH_RESPAWN = 2;
  localparam int PH_OVER    = 3;

  logic       clk = 1'b0;
  logic       rst, frame_tick, move_left, move_right, hit, restart;
  logic [9:0] pix_x, pix_y;

  logic [9:0] x_a, x_b;
  logic       on_a, on_b;
  logic [3:0] lives_a, lives_b;
  logic       alive_a, alive_b, expl_a, expl_b, over_a, over_b;

  player_ship dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .move_left(move_left), .move_right(move_right), .hit(hit), .restart(restart),
    .ship_x_pos(x_a), .ship_on(on_a), .lives_left(lives_a), .alive(alive_a),
    .exploding(expl_a), .game_over(over_a)
  );

  player_ship #(.SCALE(2), .X_MAX(614)) dut2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .move_left(move_left), .move_right(move_right), .hit(hit), .restart(restart),
    .ship_x_pos(x_b), .ship_on(on_b), .lives_left(lives_b), .alive(alive_b),
    .exploding(expl_b), .game_over(over_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int    m_phase, m_left, m_lives, m_vel, m_dir;
  int    m_x [2];
  int    xmax[2] = '{627, 614};
  int    scl [2] = '{1, 2};
  string sprite_rows[8];
  int    ramp_seq[5] = '{313, 315, 318, 322, 326};
  bit    hold_l, hold_r;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    checks++;
    if (observed !== 32'(expected)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = PH_ALIVE;
    m_left  = 0;
    m_lives = LIVES;
    m_vel   = 0;
    m_dir   = 0;
    m_x[0]  = X_RESET;
    m_x[1]  = X_RESET;
  endtask

  task automatic modelMove(input bit ml, input bit mr);
    int d, nx;
    if (ml != mr) begin
      d = mr ? 1 : -1;
      if (d == m_dir) m_vel = (m_vel + 1 > MAX_SPEED) ? MAX_SPEED : m_vel + 1;
      else            m_vel = 1;
      m_dir = d;
      for (int k = 0; k < 2; k++) begin
        nx = m_x[k] + d * m_vel;
        if (nx < X_MIN)   nx = X_MIN;
        if (nx > xmax[k]) nx = xmax[k];
        m_x[k] = nx;
      end
    end else begin
      m_vel = 0;
      m_dir = 0;
    end
  endtask

  task automatic modelStep(input bit r, input bit tk, input bit ml, input bit mr,
                           input bit h, input bit rs);
    if (r) begin
      modelReset();
      return;
    end
    case (m_phase)
      PH_ALIVE: begin
        if (h) begin
          m_lives--;
          m_left  = EXPLODE_FRAMES;
          m_vel   = 0;
          m_phase = PH_EXPLODE;
        end else if (tk) begin
          modelMove(ml, mr);
        end
      end
      PH_EXPLODE: begin
        if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_lives == 0) begin
              m_phase = PH_OVER;
            end else begin
              m_x[0] = X_RESET;
              m_x[1] = X_RESET;
              m_vel  = 0;
`ifdef PLAYER_SHIP_INVULN_EN
              m_phase = PH_RESPAWN;
              m_left  = INVULN_FRAMES;
`else
              m_phase = PH_ALIVE;
`endif
            end
          end
        end
      end
      PH_RESPAWN: begin
        if (tk) begin
          modelMove(ml, mr);
          m_left--;
          if (m_left == 0) m_phase = PH_ALIVE;
        end
      end
      default: begin
        if (rs) begin
          m_lives = LIVES;
          m_x[0]  = X_RESET;
          m_x[1]  = X_RESET;
          m_vel   = 0;
          m_phase = PH_ALIVE;
        end
      end
    endcase
  endtask

  function automatic int modelShipOn(input int k, input int px, input int py);
    int s, row, col;
    bit vis;
    s = scl[k];
    if (px < m_x[k] || px >= m_x[k] + 13 * s || py < SHIP_Y || py >= SHIP_Y + 8 * s) return 0;
    row = (py - SHIP_Y) / s;
    col = (px - m_x[k]) / s;
    vis = (m_phase == PH_ALIVE) ||
          (m_phase == PH_RESPAWN && ((m_left >> BLINK_BIT) & 1) == 0);
    return (vis && sprite_rows[row].getc(col) == "#") ? 1 : 0;
  endfunction

  // One clock of stimulus: drive at negedge, step model at posedge, then
  // drop the pulses and compare registered outputs and two sprite probes.
  task automatic applyStimulus(input bit r, input bit tk, input bit ml, input bit mr,
                               input bit h, input bit rs);
    int px, py;
    @(negedge clk);
    rst = r; frame_tick = tk; move_left = ml; move_right = mr; hit = h; restart = rs;
    @(posedge clk);
    modelStep(r, tk, ml, mr, h, rs);
    #1;
    rst = 1'b0; frame_tick = 1'b0; hit = 1'b0; restart = 1'b0;
    checkOutput("x_pos", x_a, m_x[0]);
    checkOutput("x_pos_s2", x_b, m_x[1]);
    checkOutput("lives", lives_a, m_lives);
    checkOutput("alive", alive_a, (m_phase == PH_ALIVE || m_phase == PH_RESPAWN) ? 1 : 0);
    checkOutput("exploding", expl_a, (m_phase == PH_EXPLODE) ? 1 : 0);
    checkOutput("game_over", over_a, (m_phase == PH_OVER) ? 1 : 0);
    for (int k = 0; k < 2; k++) begin
      px = m_x[k] - 2 + int'($urandom_range(0, 13 * scl[k] + 3));
      py = SHIP_Y - 1 + int'($urandom_range(0, 8 * scl[k] + 1));
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      pix_x = 10'(px);
      pix_y = 10'(py);
      #1;
      checkOutput("ship_on", on_a, modelShipOn(0, px, py));
      checkOutput("ship_on_s2", on_b, modelShipOn(1, px, py));
    end
  endtask

  task automatic probeShip(input string tag, input int k, input int px, input int py,
                           input int expected);
    pix_x = 10'(px);
    pix_y = 10'(py);
    #1;
    if (k == 0) checkOutput(tag, on_a, expected);
    else        checkOutput(tag, on_b, expected);
  endtask

  task automatic runTicks(input int n, input bit ml, input bit mr);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, ml, mr, 0, 0);
  endtask

  // Tick until the model reaches ALIVE or GAME_OVER, with a hard bound.
  task automatic finishPhases();
    int guard;
    guard = 0;
    while (m_phase != PH_ALIVE && m_phase != PH_OVER && guard < 400) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      guard++;
    end
    checkOutput("phase_bound", (guard < 400) ? 1 : 0, 1);
  endtask

  initial begin
    sprite_rows[0] = "......#......";
    sprite_rows[1] = ".....###.....";
    sprite_rows[2] = ".....###.....";
    sprite_rows[3] = ".###########.";
    sprite_rows[4] = "#############";
    sprite_rows[5] = "#############";
    sprite_rows[6] = "#############";
    sprite_rows[7] = "#############";
    rst = 1'b1; frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
    hit = 1'b0; restart = 1'b0; pix_x = '0; pix_y = '0;
    modelReset();

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_x", x_a, 312);
    checkOutput("rst_lives", lives_a, 3);
    checkOutput("rst_alive", alive_a, 1);
    checkOutput("rst_expl", expl_a, 0);
    checkOutput("rst_over", over_a, 0);

    // Scaled sprite: tip cell (row 0, col 6) covers x+12..x+13, rows 440..441
    probeShip("s2_tip_a", 1, 324, 440, 1);
    probeShip("s2_tip_b", 1, 325, 441, 1);
    probeShip("s2_dark", 1, 323, 440, 0);
    probeShip("s1_tip", 0, 318, 440, 1);
    probeShip("s1_dark", 0, 317, 440, 0);

    // Velocity ramp to the right
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 0);
      if (i < 5) checkOutput("ramp_x", x_a, ramp_seq[i]);
    end

    // Left edge clamp, then creep to x=2 and approach the edge slowly
    runTicks(100, 1, 0);
    checkOutput("left_clamp", x_a, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("x_at_2", x_a, 2);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("left_step1", x_a, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("left_step0", x_a, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("left_hold0", x_a, 0);

    // Right edge clamp
    runTicks(200, 0, 1);
    checkOutput("right_clamp", x_a, 627);
    checkOutput("right_clamp_s2", x_b, 614);

    // Hit together with a movement tick: no movement, explosion starts
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("hit_lives", lives_a, 2);
    checkOutput("hit_expl", expl_a, 1);
    checkOutput("hit_x", x_a, 627);
    probeShip("hit_dark_tip", 0, 633, 440, 0);
    probeShip("hit_dark_base", 0, 627, 447, 0);

    // restart is ignored while exploding; ticks separated by idle cycles
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("restart_ign", expl_a, 1);
    for (int i = 0; i < 31; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("expl_31", expl_a, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("expl_done", expl_a, 0);
    checkOutput("respawn_x", x_a, 312);
    checkOutput("respawn_alive", alive_a, 1);

`ifdef PLAYER_SHIP_INVULN_EN
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("invuln_lives", lives_a, 2);
    checkOutput("invuln_alive", alive_a, 1);
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      probeShip("blink", 0, 318, 440,
                (k == 64) ? 1 : ((((64 - k) >> BLINK_BIT) & 1) == 0 ? 1 : 0));
    end
`else
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("next_hit_lives", lives_a, 1);
    checkOutput("next_hit_expl", expl_a, 1);
    finishPhases();
`endif

    // Spend the remaining lives, letting every phase run out
    for (int i = 0; i < 3 && m_phase != PH_OVER; i++) begin
      applyStimulus(0, 1, 1, 0, 1, 0);
      finishPhases();
    end
    checkOutput("final_lives", lives_a, 0);
    checkOutput("final_over", over_a, 1);
    checkOutput("final_alive", alive_a, 0);
    runTicks(5, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("restart_lives", lives_a, 3);
    checkOutput("restart_x", x_a, 312);
    checkOutput("restart_alive", alive_a, 1);

    // Reset in the middle of an explosion
    applyStimulus(0, 0, 0, 0, 1, 0);
    runTicks(5, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("midrst_expl", expl_a, 0);
    checkOutput("midrst_lives", lives_a, 3);

    // Randomised run against the model
    hold_l = 1'b0;
    hold_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hold_l = 1'($urandom);
        hold_r = 1'($urandom);
      end
      applyStimulus(($urandom_range(0, 599) == 0),
                    ($urandom_range(0, 2) == 0),
                    hold_l, hold_r,
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
